// File: rtl/af_contrast_eval.sv
// af_contrast_eval: 6x6 gray-contrast accumulation over 2x2/4x4/6x6 windows and focus window selection
module af_contrast_eval (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       out_valid,
    output logic [1:0] out_focus
);
    typedef enum logic [2:0] {IDLE, COLLECT, DIV, DECIDE, OUT} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_row, r_col;
    logic [5:0][7:0] r_line;
    logic [7:0]  r_left;
    logic [13:0] r_s6;
    logic [12:0] r_s4;
    logic [9:0]  r_s2;
    logic [13:0] r_dvd;
    logic [5:0]  r_rem;
    logic [3:0]  r_cnt;
    logic [1:0]  r_focus;
    logic        w_acc, w_last, w_hv, w_vv, w_h4, w_v4, w_h2, w_v2, w_ge;
    logic [7:0]  w_gray, w_dh, w_dv, w_ch, w_cv;
    logic [8:0]  w_add6, w_add4, w_add2;
    logic [13:0] w_s6_nxt, w_a2, w_a4;
    logic [6:0]  w_trial;
    logic [1:0]  w_dec;

    assign in_ready  = (r_state == IDLE) || (r_state == COLLECT);
    assign out_valid = (r_state == OUT);
    assign out_focus = (r_state == OUT) ? r_focus : 2'd0;
    assign w_acc     = in_valid && in_ready;
    assign w_last    = (r_row == 3'd5) && (r_col == 3'd5);
    assign w_gray    = (in_r >> 2) + (in_g >> 1) + (in_b >> 2);
    assign w_dh      = (w_gray > r_left) ? w_gray - r_left : r_left - w_gray;
    assign w_dv      = (w_gray > r_line[5]) ? w_gray - r_line[5] : r_line[5] - w_gray;
    assign w_hv      = (r_col != 3'd0);
    assign w_vv      = (r_row != 3'd0);
    // a pair lies inside a window only if both endpoints do, so the leading endpoint must be one step inside
    assign w_h4      = w_hv && (r_row >= 3'd1) && (r_row <= 3'd4) && (r_col >= 3'd2) && (r_col <= 3'd4);
    assign w_v4      = w_vv && (r_col >= 3'd1) && (r_col <= 3'd4) && (r_row >= 3'd2) && (r_row <= 3'd4);
    assign w_h2      = (r_row >= 3'd2) && (r_row <= 3'd3) && (r_col == 3'd3);
    assign w_v2      = (r_col >= 3'd2) && (r_col <= 3'd3) && (r_row == 3'd3);
    assign w_ch      = w_hv ? w_dh : 8'd0;
    assign w_cv      = w_vv ? w_dv : 8'd0;
    assign w_add6    = {1'b0, w_ch} + {1'b0, w_cv};
    assign w_add4    = {1'b0, w_h4 ? w_dh : 8'd0} + {1'b0, w_v4 ? w_dv : 8'd0};
    assign w_add2    = {1'b0, w_h2 ? w_dh : 8'd0} + {1'b0, w_v2 ? w_dv : 8'd0};
    assign w_s6_nxt  = r_s6 + {5'd0, w_add6};
    assign w_trial   = {r_rem, r_dvd[13]};
    assign w_ge      = (w_trial >= 7'd36);
    assign w_a2      = {4'd0, r_s2} >> 2;
    assign w_a4      = {1'd0, r_s4} >> 4;
    assign w_dec     = (w_a2 >= w_a4 && w_a2 >= r_dvd) ? 2'd0 :
                       (w_a4 > w_a2 && w_a4 >= r_dvd) ? 2'd1 : 2'd2;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state logic: frame collect, 14-cycle divide, decide, one-cycle result
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = COLLECT;
            COLLECT: if (w_acc && w_last) w_next = DIV;
            DIV:     if (r_cnt == 4'd13) w_next = DECIDE;
            DECIDE:  w_next = OUT;
            default: w_next = IDLE;
        endcase
    end

    // pixel datapath, accumulators, restoring divider by 36 and focus decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= 3'd0;
            r_col   <= 3'd0;
            r_line  <= '0;
            r_left  <= 8'd0;
            r_s6    <= 14'd0;
            r_s4    <= 13'd0;
            r_s2    <= 10'd0;
            r_dvd   <= 14'd0;
            r_rem   <= 6'd0;
            r_cnt   <= 4'd0;
            r_focus <= 2'd0;
        end else begin
            if (w_acc) begin
                r_line <= {r_line[4:0], w_gray};
                r_left <= w_gray;
                r_col  <= (r_col == 3'd5) ? 3'd0 : r_col + 3'd1;
                r_row  <= (r_col == 3'd5) ? r_row + 3'd1 : r_row;
                r_s6   <= w_s6_nxt;
                r_s4   <= r_s4 + {4'd0, w_add4};
                r_s2   <= r_s2 + {1'd0, w_add2};
                if (w_last) begin
                    r_dvd <= w_s6_nxt;
                    r_rem <= 6'd0;
                    r_cnt <= 4'd0;
                end
            end
            if (r_state == DIV) begin
                r_dvd <= {r_dvd[12:0], w_ge};
                r_rem <= w_ge ? w_trial[5:0] - 6'd36 : w_trial[5:0];
                r_cnt <= r_cnt + 4'd1;
            end
            if (r_state == DECIDE) r_focus <= w_dec;
            if (r_state == OUT) begin
                r_row <= 3'd0;
                r_col <= 3'd0;
                r_s6  <= 14'd0;
                r_s4  <= 13'd0;
                r_s2  <= 10'd0;
            end
        end
    end
endmodule

// File: tb/tb_af_contrast_eval.sv
// tb_af_contrast_eval: directed frames with hand-computed focus results and latency checks
module tb_af_contrast_eval;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r, in_g, in_b;
    logic       out_valid;
    logic [1:0] out_focus;
    int         n_cmp = 0;
    int         n_err = 0;

    af_contrast_eval dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_focus(out_focus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // gray 0 (dark), 252 (bright) and 149 (uniform) with channels chosen so truncation matters
    function automatic logic [23:0] pix(input int pat, input int r, input int c);
        logic [23:0] bright, dark;
        bright = {8'd255, 8'd253, 8'd254};
        dark   = {8'd3, 8'd1, 8'd3};
        if (pat == 0) return {8'd103, 8'd201, 8'd99};
        if (pat == 1) return ((r + c) % 2 == 1) ? bright : dark;
        return (r == 1 && c == 1) ? bright : dark;
    endfunction

    // starts and ends at a falling edge
    task automatic beat(input logic [23:0] p);
        int t = 0;
        in_valid = 1'b1;
        {in_r, in_g, in_b} = p;
        while (!in_ready && t < 40) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input int pat, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            beat(pix(pat, i / 6, i % 6));
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                {in_r, in_g, in_b} = 24'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    // called at the falling edge right after the last accepted beat
    task automatic check_out(input string tag, input int exp, input bit offer);
        for (int k = 0; k <= 16; k++) begin
            chk($sformatf("%s_rdy%0d", tag, k), int'(in_ready), (k == 16) ? 1 : 0);
            chk($sformatf("%s_ov%0d", tag, k), int'(out_valid), (k == 15) ? 1 : 0);
            chk($sformatf("%s_foc%0d", tag, k), int'(out_focus), (k == 15) ? exp : 0);
            in_valid = offer && k < 15;
            {in_r, in_g, in_b} = {8'd255, 8'd253, 8'd254};
            if (k < 16) @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        {in_r, in_g, in_b} = 24'd0;
        repeat (3) @(negedge clk);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_foc", int'(out_focus), 0);
        chk("rst_rdy", int'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        send(0, 1'b0, 36);
        check_out("uni", 0, 1'b0);
        send(1, 1'b0, 36);
        check_out("chk", 2, 1'b0);
        send(2, 1'b0, 36);
        check_out("one", 1, 1'b0);
        send(1, 1'b1, 36);
        check_out("tog", 2, 1'b1);
        send(1, 1'b0, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ov", int'(out_valid), 0);
        chk("abort_rdy", int'(in_ready), 1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle%0d", i), int'(out_valid), 0);
        end
        send(0, 1'b0, 36);
        check_out("rst_uni", 0, 1'b0);
        send(2, 1'b0, 36);
        check_out("b2b1", 1, 1'b0);
        send(1, 1'b0, 36);
        check_out("b2b2", 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
